// File: rtl/ubcd_scan_display.sv
// Multi-digit 7-segment scanner: staged digit writes, frame-synchronous commit, one-hot scan.
// Define UBCD_LZB_EN to enable leading-zero blanking in hex/decimal modes.
module ubcd_scan_display #(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 1024,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit DIG_ACTIVE_LOW = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic                          wr_en,
  input  logic [$clog2(NUM_DIGITS)-1:0] wr_addr,
  input  logic [4:0]                    wr_data,
  input  logic                          commit,
  input  logic [1:0]                    mode,
  output logic [6:0]                    seg,
  output logic                          dp,
  output logic [NUM_DIGITS-1:0]         dig_sel,
  output logic                          pending,
  output logic                          commit_done
);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {ST_IDLE, ST_PENDING} state_t;

  state_t                state_reg, state_next;
  logic [PRE_W-1:0]      presc_reg;
  logic [IDX_W-1:0]      idx_reg;
  logic [4:0]            staging_reg  [NUM_DIGITS];
  logic [4:0]            staging_next [NUM_DIGITS];
  logic [4:0]            display_reg  [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] lzb_blank;
  logic                  commit_done_reg;
  logic [6:0]            seg_reg, seg_next;
  logic                  dp_reg, dp_next;
  logic [NUM_DIGITS-1:0] dig_reg, dig_next;
  logic                  slot_end, boundary, copy;
  logic [4:0]            cur_digit;
  logic                  cur_blank;

  function automatic logic [6:0] hex_seg(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign slot_end = ena && (presc_reg == PRE_LAST);
  assign boundary = slot_end && (idx_reg == IDX_LAST);

  // Same-edge writes are folded in here so a write on the boundary cycle is what gets displayed.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_stage
      assign staging_next[gi] = (wr_en && (wr_addr == IDX_W'(gi))) ? wr_data : staging_reg[gi];
    end
  endgenerate

`ifdef UBCD_LZB_EN
  // zero_above[i]: digits i..NUM_DIGITS-1 are all code 0 with dp clear.
  logic [NUM_DIGITS:1] zero_above;
  assign zero_above[NUM_DIGITS] = 1'b1;
  assign lzb_blank[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_lzb
      assign zero_above[gi] = zero_above[gi+1] && (display_reg[gi] == 5'd0);
      assign lzb_blank[gi]  = zero_above[gi];
    end
  endgenerate
`else
  assign lzb_blank = '0;
`endif

  always_comb begin
    state_next = state_reg;
    copy       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (boundary && commit) begin
          copy = 1'b1;
        end else if (commit) begin
          state_next = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (boundary) begin
          copy       = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      presc_reg       <= '0;
      idx_reg         <= '0;
      commit_done_reg <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        staging_reg[i] <= '0;
        display_reg[i] <= '0;
      end
    end else begin
      state_reg       <= state_next;
      commit_done_reg <= copy;
      if (ena) begin
        presc_reg <= slot_end ? '0 : presc_reg + 1'b1;
      end
      if (slot_end) begin
        idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
      end
      for (int i = 0; i < NUM_DIGITS; i++) begin
        staging_reg[i] <= staging_next[i];
        if (copy) begin
          display_reg[i] <= staging_next[i];
        end
      end
    end
  end

  assign cur_digit = display_reg[idx_reg];
  assign cur_blank = lzb_blank[idx_reg];

  // The last prescaler cycle of each slot is dark so digit switching never ghosts.
  always_comb begin
    seg_next = 7'h00;
    dp_next  = 1'b0;
    dig_next = '0;
    if (presc_reg != PRE_LAST) begin
      dig_next = NUM_DIGITS'(1) << idx_reg;
      case (mode)
        2'b00: begin
          if (!cur_blank) begin
            seg_next = hex_seg(cur_digit[3:0]);
            dp_next  = cur_digit[4];
          end
        end
        2'b01: begin
          if (!cur_blank) begin
            seg_next = (cur_digit[3:0] > 4'd9) ? 7'h40 : hex_seg(cur_digit[3:0]);
            dp_next  = cur_digit[4];
          end
        end
        2'b10: begin
          seg_next = 7'h00;
          dp_next  = 1'b0;
        end
        default: begin
          seg_next = 7'h7F;
          dp_next  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_reg <= {7{SEG_ACTIVE_LOW}};
      dp_reg  <= SEG_ACTIVE_LOW;
      dig_reg <= {NUM_DIGITS{DIG_ACTIVE_LOW}};
    end else begin
      seg_reg <= seg_next ^ {7{SEG_ACTIVE_LOW}};
      dp_reg  <= dp_next ^ SEG_ACTIVE_LOW;
      dig_reg <= dig_next ^ {NUM_DIGITS{DIG_ACTIVE_LOW}};
    end
  end

  assign seg         = seg_reg;
  assign dp          = dp_reg;
  assign dig_sel     = dig_reg;
  assign pending     = (state_reg == ST_PENDING);
  assign commit_done = commit_done_reg;

endmodule

// File: tb/tb_ubcd_scan_display.sv
// Scoreboard bench for ubcd_scan_display (4 digits, 4-cycle slots); a second instance
// with inverted pin polarity is checked against the same expectations.
`timescale 1ns/1ps
module tb_ubcd_scan_display;
  localparam int ND = 4;
  localparam int SD = 4;
`ifdef UBCD_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif
  // A zero digit with only zeros above it: blank with leading-zero blanking, "0" otherwise.
  localparam logic [6:0] Z0 = LZB ? 7'h00 : 7'h3F;

  logic clk = 1'b0;
  logic rst_n = 1'b0, ena = 1'b0, wr_en = 1'b0, commit = 1'b0;
  logic [1:0] wr_addr = '0;
  logic [4:0] wr_data = '0;
  logic [1:0] mode = '0;
  logic [6:0] seg, seg_inv;
  logic dp, dp_inv, pending, pending_inv, done, done_inv;
  logic [ND-1:0] dig, dig_inv;

  ubcd_scan_display #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit(commit), .mode(mode), .seg(seg), .dp(dp), .dig_sel(dig), .pending(pending),
    .commit_done(done));

  ubcd_scan_display #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)) dut_inv (
    .clk(clk), .rst_n(rst_n), .ena(ena), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit(commit), .mode(mode), .seg(seg_inv), .dp(dp_inv), .dig_sel(dig_inv), .pending(pending_inv),
    .commit_done(done_inv));

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    bit         chk_out;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] dig;
    logic       pend;
    logic       done;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expect the given pin state after d more rising edges.
  task automatic push(input int d, input bit co, input logic [6:0] s, input logic p,
                      input logic [3:0] g, input logic pe, input logic dn);
    exp_t x;
    x.cyc = cyc + d; x.chk_out = co; x.seg = s; x.dp = p; x.dig = g; x.pend = pe; x.done = dn;
    q.push_back(x);
  endtask

  task automatic status(input int d, input logic pe, input logic dn);
    push(d, 1'b0, 7'h00, 1'b0, 4'h0, pe, dn);
  endtask

  // One full frame starting at a frame boundary: 3 lit cycles then 1 dark cycle per slot.
  task automatic frame_expect(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                              input logic [6:0] s3, input logic dpv);
    logic [6:0] s [4];
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    for (int sl = 0; sl < 4; sl++) begin
      for (int p = 0; p < 4; p++) begin
        if (p < 3) push(sl * 4 + p + 1, 1'b1, s[sl], dpv, 4'(1 << sl), 1'b0, 1'b0);
        else       push(sl * 4 + p + 1, 1'b1, 7'h00, 1'b0, 4'h0, 1'b0, 1'b0);
      end
    end
    repeat (16) tick();
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      n_chk++;
      if (e.cyc != cyc) begin
        $display("FAIL late_check stamp=%0d now=%0d", e.cyc, cyc);
      end else if (e.chk_out && ({seg, dp, dig, pending, done} !== {e.seg, e.dp, e.dig, e.pend, e.done})) begin
        $display("FAIL pins cyc=%0d got seg=%h dp=%b dig=%b pend=%b done=%b want seg=%h dp=%b dig=%b pend=%b done=%b",
                 cyc, seg, dp, dig, pending, done, e.seg, e.dp, e.dig, e.pend, e.done);
      end else if (!e.chk_out && ({pending, done} !== {e.pend, e.done})) begin
        $display("FAIL status cyc=%0d got pend=%b done=%b want pend=%b done=%b",
                 cyc, pending, done, e.pend, e.done);
      end else begin
        n_pass++;
        $display("check cyc=%0d seg=%h dp=%b dig=%b pend=%b done=%b ok", cyc, seg, dp, dig, pending, done);
      end
      if (e.chk_out) begin
        n_chk++;
        if ({seg_inv, dp_inv, dig_inv, pending_inv, done_inv} !== {~e.seg, ~e.dp, ~e.dig, e.pend, e.done}) begin
          $display("FAIL inv_pins cyc=%0d got seg=%h dp=%b dig=%b want seg=%h dp=%b dig=%b",
                   cyc, seg_inv, dp_inv, dig_inv, ~e.seg, ~e.dp, ~e.dig);
        end else begin
          n_pass++;
        end
      end
    end
  end

  initial begin
    // Reset state, then first lit slot one cycle after release.
    rst_n = 1'b0; ena = 1'b1;
    tick(); tick();
    push(0, 1'b1, 7'h00, 1'b0, 4'b0000, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    push(1, 1'b1, 7'h3F, 1'b0, 4'b0001, 1'b0, 1'b0);
    tick();

    // Stage 1,2,3,4 and commit mid-frame.
    for (int a = 0; a < 4; a++) begin
      wr_en = 1'b1; wr_addr = 2'(a); wr_data = 5'(a + 1);
      tick();
    end
    wr_en = 1'b0; commit = 1'b1;
    push(1, 1'b1, Z0, 1'b0, 4'b0010, 1'b1, 1'b0);
    tick();
    commit = 1'b0;
    status(9, 1'b1, 1'b0);
    push(10, 1'b1, 7'h00, 1'b0, 4'b0000, 1'b0, 1'b1);
    repeat (10) tick();
    frame_expect(7'h06, 7'h5B, 7'h4F, 7'h66, 1'b0);

    // Code B into digit 2, then walk through the four modes.
    wr_en = 1'b1; wr_addr = 2'd2; wr_data = 5'h0B; commit = 1'b1;
    status(1, 1'b1, 1'b0);
    tick();
    wr_en = 1'b0; commit = 1'b0;
    status(15, 1'b0, 1'b1);
    repeat (15) tick();
    mode = 2'b01; frame_expect(7'h06, 7'h5B, 7'h40, 7'h66, 1'b0);
    mode = 2'b00; frame_expect(7'h06, 7'h5B, 7'h7C, 7'h66, 1'b0);
    mode = 2'b11; frame_expect(7'h7F, 7'h7F, 7'h7F, 7'h7F, 1'b1);
    mode = 2'b10; frame_expect(7'h00, 7'h00, 7'h00, 7'h00, 1'b0);
    mode = 2'b00;

    // Double commit while pending, plus a write on the boundary cycle.
    commit = 1'b1;
    status(1, 1'b1, 1'b0);
    tick();
    commit = 1'b0; tick();
    commit = 1'b1;
    status(1, 1'b1, 1'b0);
    tick();
    commit = 1'b0;
    repeat (12) tick();
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 5'h07; commit = 1'b1;
    status(1, 1'b0, 1'b1);
    tick();
    wr_en = 1'b0; commit = 1'b0;
    frame_expect(7'h06, 7'h07, 7'h7C, 7'h66, 1'b0);

    // Freeze scanning mid-slot; a commit made while frozen must wait.
    repeat (5) tick();
    ena = 1'b0; commit = 1'b1;
    push(1, 1'b1, 7'h07, 1'b0, 4'b0010, 1'b1, 1'b0);
    tick();
    commit = 1'b0;
    for (int i = 0; i < 9; i++) begin
      push(1, 1'b1, 7'h07, 1'b0, 4'b0010, 1'b1, 1'b0);
      tick();
    end
    ena = 1'b1;
    for (int i = 0; i < 2; i++) begin
      push(1, 1'b1, 7'h07, 1'b0, 4'b0010, 1'b1, 1'b0);
      tick();
    end

    // Reset mid-frame with a commit pending.
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      push(1, 1'b1, 7'h00, 1'b0, 4'b0000, 1'b0, 1'b0);
      tick();
    end
    rst_n = 1'b1;
    frame_expect(7'h3F, Z0, Z0, Z0, 1'b0);

    // Code 8 on digit 0 lights every segment (all low on the inverted instance).
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 5'h08; commit = 1'b1;
    status(1, 1'b1, 1'b0);
    tick();
    wr_en = 1'b0; commit = 1'b0;
    status(15, 1'b0, 1'b1);
    repeat (15) tick();
    frame_expect(7'h7F, Z0, Z0, Z0, 1'b0);

`ifdef UBCD_LZB_EN
    // Digits 3..0 = 0,0,4,2: the two upper zeros go dark.
    for (int a = 0; a < 4; a++) begin
      wr_en = 1'b1; wr_addr = 2'(a);
      wr_data = (a == 0) ? 5'h02 : (a == 1) ? 5'h04 : 5'h00;
      commit = (a == 3);
      if (a == 3) status(1, 1'b1, 1'b0);
      tick();
    end
    wr_en = 1'b0; commit = 1'b0;
    status(12, 1'b0, 1'b1);
    repeat (12) tick();
    frame_expect(7'h5B, 7'h66, 7'h00, 7'h00, 1'b0);
`endif

    tick(); tick();
    n_chk++;
    if (q.size() != 0) $display("FAIL queue_drain got %0d left want 0", q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
